// File: rtl/uart_tx_engine.sv
// UART transmit engine: serializes one byte into a fixed 11-bit-time frame on tx
// and pulses txrdy for one cycle when the last bit time ends.
module uart_tx_engine #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [7:0]        out_port,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    input  logic [BAUD_W-1:0] k,
    output logic              tx,
    output logic              busy,
    output logic              txrdy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]        r_state;
    logic [10:0]       r_shift;
    logic [BAUD_W-1:0] r_k_lat;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [3:0]        r_bit_cnt;
    logic              r_txrdy;

    logic              w_data_xor;
    logic              w_parity;
    logic [10:0]       w_frame;
    logic [BAUD_W-1:0] w_k_eff;
    logic              w_baud_tc;
    logic              w_last_bit;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_data_xor = eight ? ^out_port : ^out_port[6:0];
        w_parity   = w_data_xor ^ ohel;
        w_frame    = '1;
        case ({eight, pen})
            2'b11:   w_frame = {1'b1, w_parity, out_port, 1'b0};
            2'b10:   w_frame = {2'b11, out_port, 1'b0};
            2'b01:   w_frame = {2'b11, w_parity, out_port[6:0], 1'b0};
            default: w_frame = {3'b111, out_port[6:0], 1'b0};
        endcase
    end

    // k of 0 and 1 both mean one clock per bit.
    assign w_k_eff    = (k <= BAUD_W'(1)) ? BAUD_W'(1) : k;
    assign w_baud_tc  = (r_baud_cnt == r_k_lat - BAUD_W'(1));
    assign w_last_bit = (r_bit_cnt == 4'd10);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_shift    <= '1;
            r_k_lat    <= BAUD_W'(1);
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_txrdy    <= 1'b0;
        end else begin
            r_txrdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_state    <= SHIFT;
                        r_shift    <= w_frame;
                        r_k_lat    <= w_k_eff;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (w_baud_tc) begin
                        r_baud_cnt <= '0;
                        // Filling with ones leaves the line idle-high once the frame drains.
                        r_shift    <= {1'b1, r_shift[10:1]};
                        if (w_last_bit) begin
                            r_state   <= IDLE;
                            r_bit_cnt <= '0;
                            r_txrdy   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx    = r_shift[0];
    assign busy  = (r_state == SHIFT);
    assign txrdy = r_txrdy;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: hand-computed frames checked bit time by bit time.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [7:0]  out_port;
    logic        eight;
    logic        pen;
    logic        ohel;
    logic [18:0] k;
    logic        tx;
    logic        busy;
    logic        txrdy;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;
    int n_txrdy      = 0;
    int txrdy_cyc[$];

    uart_tx_engine #(.BAUD_W(19)) dut (
        .clk(clk), .reset(reset), .load(load), .out_port(out_port),
        .eight(eight), .pen(pen), .ohel(ohel), .k(k),
        .tx(tx), .busy(busy), .txrdy(txrdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (txrdy === 1'b1) begin
            n_txrdy++;
            txrdy_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] d, input logic e8, input logic pe,
                           input logic od, input logic [18:0] kk);
        load = 1'b1; out_port = d; eight = e8; pen = pe; ohel = od; k = kk;
        tick();
        load = 1'b0;
    endtask

    // Called right after the load edge; returns in the txrdy cycle.
    // glitch >= 0 pulses a second load with different data/config at that cycle.
    task automatic run_frame(input string name, input logic [10:0] bits,
                             input int kk, input int glitch);
        int keff = (kk <= 1) ? 1 : kk;
        int c = 0;
        for (int b = 0; b < 11; b++) begin
            for (int j = 0; j < keff; j++) begin
                check($sformatf("%s tx b%0d c%0d", name, b, j), tx, bits[b]);
                check($sformatf("%s busy b%0d c%0d", name, b, j), busy, 1'b1);
                check($sformatf("%s txrdy b%0d c%0d", name, b, j), txrdy, 1'b0);
                if (c == glitch) begin
                    load = 1'b1; out_port = 8'hFF; eight = 1'b0; pen = 1'b1; k = 19'd7;
                end
                tick();
                load = 1'b0;
                c++;
            end
        end
        check({name, " done txrdy"}, txrdy, 1'b1);
        check({name, " done busy"}, busy, 1'b0);
        check({name, " done tx"}, tx, 1'b1);
    endtask

    initial begin
        int saved;
        reset = 1'b1; load = 1'b0; out_port = 8'h00; eight = 1'b1; pen = 1'b0; ohel = 1'b0; k = 19'd1;
        tick();

        // Reset with arbitrary inputs, including an active load.
        load = 1'b1; out_port = 8'h3C; k = 19'd5; pen = 1'b1;
        reset = 1'b0;
        #1;
        check("rst tx", tx, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst txrdy", txrdy, 1'b0);
        tick(); tick();
        load = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post-rst tx", tx, 1'b1);
            check("post-rst busy", busy, 1'b0);
            check("post-rst txrdy", txrdy, 1'b0);
        end

        // 0xA5, 8 bits, even parity, k=4.
        saved = n_txrdy;
        do_load(8'hA5, 1'b1, 1'b1, 1'b0, 19'd4);
        run_frame("a5_even", 11'h54A, 4, -1);
        tick();
        check("a5 txrdy one cycle", txrdy, 1'b0);
        check("a5 txrdy count", n_txrdy - saved, 1);

        // 0x41, 7 bits, odd parity, k=2.
        do_load(8'h41, 1'b0, 1'b1, 1'b1, 19'd2);
        run_frame("41_odd", 11'h782, 2, -1);
        tick();

        // k=0 behaves as one clock per bit; 7 bits, no parity.
        do_load(8'h7F, 1'b0, 1'b0, 1'b0, 19'd0);
        run_frame("7f_k0", 11'h7FE, 0, -1);
        tick();

        // Load while busy: ignored, single frame and single txrdy.
        saved = n_txrdy;
        do_load(8'h00, 1'b1, 1'b0, 1'b0, 19'd3);
        run_frame("busy_load", 11'h600, 3, 13);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("busy_load idle tx", tx, 1'b1);
            check("busy_load idle busy", busy, 1'b0);
        end
        check("busy_load txrdy count", n_txrdy - saved, 1);

        // Back-to-back at k=1: second load during the txrdy cycle.
        saved = n_txrdy;
        txrdy_cyc.delete();
        do_load(8'h55, 1'b1, 1'b0, 1'b0, 19'd1);
        run_frame("b2b_55", 11'h6AA, 1, -1);
        do_load(8'hAA, 1'b1, 1'b0, 1'b0, 19'd1);
        run_frame("b2b_aa", 11'h754, 1, -1);
        tick();
        check("b2b txrdy count", n_txrdy - saved, 2);
        if (txrdy_cyc.size() == 2)
            check("b2b txrdy spacing", txrdy_cyc[1] - txrdy_cyc[0], 12);
        else
            check("b2b txrdy entries", txrdy_cyc.size(), 2);

        // Reset mid-frame at bit 5, then a clean frame.
        saved = n_txrdy;
        do_load(8'h3C, 1'b1, 1'b1, 1'b1, 19'd2);
        for (int i = 0; i < 10; i++) tick();
        check("abort bit5 busy", busy, 1'b1);
        check("abort bit5 tx", tx, 1'b1);
        reset = 1'b0;
        #1;
        check("abort tx", tx, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort txrdy", txrdy, 1'b0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abort idle tx", tx, 1'b1);
            check("abort idle busy", busy, 1'b0);
        end
        check("abort no txrdy", n_txrdy - saved, 0);
        do_load(8'h0F, 1'b1, 1'b1, 1'b0, 19'd2);
        run_frame("after_abort_0f", 11'h41E, 2, -1);
        tick();
        check("after_abort txrdy count", n_txrdy - saved, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Serial transmit engine for the full UART. It accepts a byte from the Tramelblaze output port, serializes it as a fixed 11-bit-time asynchronous frame on `tx`, and emits a one-cycle `txrdy` pulse on completion. `txrdy` feeds the set input of the transmit-interrupt SR flop directly upstream of the processor interrupt line.

## Interface
- `BAUD_W`, 19: width of the bit-time divisor `k`.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0). Resets all state immediately.
- `load`  in  1  one-cycle write strobe from the processor. Accepted only while `busy`=0.
- `out_port`  in  8  transmit data; sampled on the accepted `load`.
- `eight`  in  1  1 = 8 data bits, 0 = 7 data bits (`out_port[6:0]`).
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 1 = odd, 0 = even.
- `k`  in  BAUD_W  bit time in clocks; sampled on the accepted `load`. Values 0 and 1 both mean 1 clock per bit.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high from the accepted `load` until frame completion.
- `txrdy`  out  1  one-cycle completion pulse, routed to the SR interrupt set input.

## Operation
- States: IDLE and SHIFT.
- IDLE:
  - `tx`=1, `busy`=0.
  - A `load` moves the block to SHIFT.
  - On that transition it latches `k`, and it builds the 11-bit frame in the shift register (LSB is sent first):
    - `eight`=1, `pen`=1: start 0, d0..d7, parity, stop 1.
    - `eight`=1, `pen`=0: start, d0..d7, 1, 1.
    - `eight`=0, `pen`=1: start, d0..d6, parity, 1, 1.
    - `eight`=0, `pen`=0: start, d0..d6, 1, 1, 1.
  - Parity is computed over the transmitted data bits only:
    - even: XOR of those bits;
    - odd: the inverse of that XOR.
- SHIFT:
  - `tx` = shift register LSB.
  - The baud counter counts 0..k_lat-1.
  - At terminal count the block shifts right, filling with 1, and increments the bit counter (0..10).
  - At the terminal count of bit 10 it returns to IDLE and pulses `txrdy`.
- A `load` while `busy`=1 is ignored. Data, config and timing are unaffected.
- Changes to `k`, `eight`, `pen`, `ohel` or `out_port` during SHIFT have no effect.
- Reset asserted mid-frame aborts the frame: `tx`=1 immediately, and no `txrdy` is generated.
- `tx` is driven from a register (glitch-free).

## Timing
- Reset values: `tx`=1, `busy`=0, `txrdy`=0. Counters are 0 and the state is IDLE.
- With `load` sampled high at edge E0:
  - `busy`=1 and `tx`=0 (start bit) after E0.
  - Each bit is held exactly k_lat clocks.
  - The frame occupies exactly 11·k_lat clocks.
- At edge E0 + 11·k_lat:
  - `txrdy`=1 for exactly one cycle;
  - `busy`=0;
  - `tx`=1.
- Back-to-back: a `load` in the cycle where `txrdy`=1 is accepted. The next start bit begins on the following edge, with no idle gap beyond that cycle.
- k_lat=1: one bit per clock, with the frame 11 clocks long.

## Test plan
- Reset: drive `reset`=0 mid-simulation with arbitrary inputs. Required: `tx`=1, `busy`=0, `txrdy`=0. The outputs hold after release until a `load`.
- 8-bit even parity: `out_port`=0xA5, `eight`=1, `pen`=1, `ohel`=0, `k`=4. Required:
  - `tx` bits 0,1,0,1,0,0,1,0,1,0,1, each 4 clocks;
  - `txrdy` pulses 44 clocks after the load edge.
- 7-bit odd parity: `out_port`=0x41, `eight`=0, `pen`=1, `ohel`=1, `k`=2. Required: bits 0,1,0,0,0,0,0,1,1,1,1, each 2 clocks, with `txrdy` at 22 clocks.
- Load while busy: second `load` with 0xFF issued mid-frame of 0x00 (`eight`=1, `pen`=0, `k`=3). Required:
  - frame 0,0×8,1,1 unchanged;
  - a single `txrdy`;
  - no second frame.
- Back-to-back at `k`=1: `load` 0x55, then `load` 0xAA asserted during the `txrdy` cycle. Required: two contiguous 11-clock frames and two `txrdy` pulses 12 clocks apart.
- Reset mid-frame at bit 5, then release and `load` 0x0F. Required:
  - `tx`=1 immediately on reset, with no `txrdy` for the aborted frame;
  - the new frame is correct from its start bit.
